// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//   ID/EX pipeline register of the pipelined RV core.  Captures the decode
//   control word and operand data for the instruction leaving ID.  It also
//   detects load-use hazards against the instruction currently in EX.
//
//   Update priority on each rising edge of clk:
//       reset > flush_i > hold_i > stall_o > normal load.
//   A flush or a stall loads a bubble.  In a bubble the control bits,
//   ALUOp, rd and valid are cleared, and the data fields still follow ID.
//
//   Ports
//     clk, reset         rising-edge clock, synchronous active-high reset
//     flush_i            squash the instruction entering EX (branch taken)
//     hold_i             global freeze; register keeps its contents
//     id_*_i             decode control, operands, addresses and funct
//     stall_o            load-use stall request to PC and IF/ID
//     ex_*_o             registered copies of id_*_i
//     ex_valid_o         1 = real instruction in EX, 0 = bubble
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               hold_i,

    input  logic               id_branch_i,
    input  logic               id_memread_i,
    input  logic               id_memtoreg_i,
    input  logic               id_memwrite_i,
    input  logic               id_alusrc_i,
    input  logic               id_regwrite_i,
    input  logic [1:0]         id_aluop_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [XLEN-1:0]    id_rs1_data_i,
    input  logic [XLEN-1:0]    id_rs2_data_i,
    input  logic [XLEN-1:0]    id_imm_i,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    input  logic [RADDR_W-1:0] id_rd_i,
    input  logic [3:0]         id_funct_i,

    output logic               stall_o,
    output logic               ex_branch_o,
    output logic               ex_memread_o,
    output logic               ex_memtoreg_o,
    output logic               ex_memwrite_o,
    output logic               ex_alusrc_o,
    output logic               ex_regwrite_o,
    output logic [1:0]         ex_aluop_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [XLEN-1:0]    ex_rs1_data_o,
    output logic [XLEN-1:0]    ex_rs2_data_o,
    output logic [XLEN-1:0]    ex_imm_o,
    output logic [RADDR_W-1:0] ex_rs1_o,
    output logic [RADDR_W-1:0] ex_rs2_o,
    output logic [RADDR_W-1:0] ex_rd_o,
    output logic [3:0]         ex_funct_o,
    output logic               ex_valid_o
);

    // Control word order: {branch, memread, memtoreg, memwrite, alusrc, regwrite}
    logic [5:0]         ctrl_q,     ctrl_d;
    logic [1:0]         aluop_q,    aluop_d;
    logic [XLEN-1:0]    pc_q,       pc_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic [RADDR_W-1:0] rs1_q,      rs1_d;
    logic [RADDR_W-1:0] rs2_q,      rs2_d;
    logic [RADDR_W-1:0] rd_q,       rd_d;
    logic [3:0]         funct_q,    funct_d;
    logic               valid_q,    valid_d;

    logic               use_rs2;
    logic               hazard;

    // rs2 is a real source for R-type and branch (alusrc = 0) and for stores.
    assign use_rs2 = ~id_alusrc_i | id_memwrite_i;

    // ctrl_q[4] is memread.  rd = x0 never creates a dependency.
    assign hazard = valid_q & ctrl_q[4] & (rd_q != '0) &
                    ((rd_q == id_rs1_i) | (use_rs2 & (rd_q == id_rs2_i)));

    // A flushed or frozen ID stage must not request a stall.
    assign stall_o = hazard & ~hold_i & ~flush_i;

    always_comb begin
        // Default: keep contents (covers hold_i).
        ctrl_d     = ctrl_q;
        aluop_d    = aluop_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct_d    = funct_q;
        valid_d    = valid_q;

        if (flush_i || !hold_i) begin
            // Data fields follow ID for both a real load and a bubble.
            pc_d       = id_pc_i;
            rs1_data_d = id_rs1_data_i;
            rs2_data_d = id_rs2_data_i;
            imm_d      = id_imm_i;
            rs1_d      = id_rs1_i;
            rs2_d      = id_rs2_i;
            funct_d    = id_funct_i;

            if (flush_i || stall_o) begin
                ctrl_d  = '0;
                aluop_d = 2'b00;
                rd_d    = '0;
                valid_d = 1'b0;
            end else begin
                ctrl_d  = {id_branch_i, id_memread_i, id_memtoreg_i,
                           id_memwrite_i, id_alusrc_i, id_regwrite_i};
                aluop_d = id_aluop_i;
                rd_d    = id_rd_i;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            aluop_q    <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            aluop_q    <= aluop_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
            valid_q    <= valid_d;
        end
    end

    assign ex_branch_o   = ctrl_q[5];
    assign ex_memread_o  = ctrl_q[4];
    assign ex_memtoreg_o = ctrl_q[3];
    assign ex_memwrite_o = ctrl_q[2];
    assign ex_alusrc_o   = ctrl_q[1];
    assign ex_regwrite_o = ctrl_q[0];
    assign ex_aluop_o    = aluop_q;
    assign ex_pc_o       = pc_q;
    assign ex_rs1_data_o = rs1_data_q;
    assign ex_rs2_data_o = rs2_data_q;
    assign ex_imm_o      = imm_q;
    assign ex_rs1_o      = rs1_q;
    assign ex_rs2_o      = rs2_q;
    assign ex_rd_o       = rd_q;
    assign ex_funct_o    = funct_q;
    assign ex_valid_o    = valid_q;

endmodule
